rgb_enc_scheduler: RTL and testbench

Time-multiplexed quadrature-encoder front end for the RGB mixer. One shared debounce/decode datapath services NCH encoder channels in round-robin slots paced by a prescaler. Each channel gets a saturating level register whose value drives the matching PWM channel. The block sits between the raw `ui_in` encoder pins and the PWM generators.

---
 rtl/rgb_pkg.sv | 32 +++
 rtl/enc_sync2.sv | 25 ++
 rtl/rgb_enc_scheduler.sv | 149 ++++++++++++++
 tb/tb_rgb_enc_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB mixer encoder front end.
// Decodes a quadrature state transition into a step direction.
package rgb_pkg;

  localparam int NCH_DEF   = 3;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN,
    STEP_ERR
  } step_t;

  // Map each state to its position on the Gray ring 00->01->11->10.
  // The position difference mod 4 then gives the step direction directly.
  function automatic step_t quad_step(input logic [1:0] old_s, input logic [1:0] new_s);
    logic [1:0] pos_old;
    logic [1:0] pos_new;
    logic [1:0] diff;
    pos_old = {old_s[1], old_s[1] ^ old_s[0]};
    pos_new = {new_s[1], new_s[1] ^ new_s[0]};
    diff    = pos_new - pos_old;
    case (diff)
      2'd0:    return STEP_NONE;
      2'd1:    return STEP_UP;
      2'd3:    return STEP_DN;
      default: return STEP_ERR;
    endcase
  endfunction

endpackage

// File: rtl/enc_sync2.sv
// Two-flop synchronizer bank for asynchronous encoder pins.
module enc_sync2 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rgb_enc_scheduler.sv
// Round-robin quadrature encoder front end: one shared debounce/decode path
// serves all channels, each owning a saturating level register.
module rgb_enc_scheduler
  import rgb_pkg::*;
#(
  parameter int NCH      = NCH_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [NCH-1:0]     enc_a,
  input  logic [NCH-1:0]     enc_b,
  input  logic               err_clr,
  output logic [NCH*WIDTH-1:0] level,
  output logic               upd_valid,
  output logic [1:0]         upd_ch,
  output logic [NCH-1:0]     err
);

  localparam int         DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] DEB   = 4'(DEBOUNCE);

  logic [2*NCH-1:0] sync_ab;
  logic [NCH-1:0]   sync_a;
  logic [NCH-1:0]   sync_b;

  enc_sync2 #(.W(2*NCH)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({enc_b, enc_a}),
    .q     (sync_ab)
  );

  assign sync_a = sync_ab[NCH-1:0];
  assign sync_b = sync_ab[2*NCH-1:NCH];

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       ptr;
  logic             tick;

  logic [1:0]       stable_q [NCH];
  logic [1:0]       cand_q   [NCH];
  logic [3:0]       cnt_q    [NCH];
  logic             init_q   [NCH];
  logic [WIDTH-1:0] level_q  [NCH];

  assign tick = ena && (div_cnt == DIV_W'(SCAN_DIV - 1));

  // Shared datapath: only the channel under ptr is evaluated each slot.
  logic [1:0]       sample;
  logic [1:0]       nxt_stable;
  logic [1:0]       nxt_cand;
  logic [3:0]       nxt_cnt;
  logic [WIDTH-1:0] nxt_level;
  logic             upd;
  logic             err_set;
  logic [NCH-1:0]   err_nxt;
  step_t            step;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    sample     = {sync_b[ptr], sync_a[ptr]};
    nxt_stable = stable_q[ptr];
    nxt_cand   = cand_q[ptr];
    nxt_cnt    = cnt_q[ptr];
    nxt_level  = level_q[ptr];
    step       = STEP_NONE;
    upd        = 1'b0;
    err_set    = 1'b0;

    if (!init_q[ptr]) begin
      nxt_stable = sample;
      nxt_cnt    = 4'd0;
    end else if (sample == stable_q[ptr]) begin
      nxt_cnt = 4'd0;
    end else begin
      if (sample != cand_q[ptr]) begin
        nxt_cand = sample;
        nxt_cnt  = 4'd1;
      end else begin
        nxt_cnt = cnt_q[ptr] + 4'd1;
      end
      if (nxt_cnt == DEB) begin
        nxt_stable = sample;
        nxt_cnt    = 4'd0;
        step       = quad_step(stable_q[ptr], sample);
      end
    end

    case (step)
      STEP_UP: if (level_q[ptr] != '1) begin
        nxt_level = level_q[ptr] + WIDTH'(1);
        upd       = 1'b1;
      end
      STEP_DN: if (level_q[ptr] != '0) begin
        nxt_level = level_q[ptr] - WIDTH'(1);
        upd       = 1'b1;
      end
      STEP_ERR: err_set = 1'b1;
      default: ;
    endcase

    // A same-cycle set beats the clear.
    err_nxt = err_clr ? '0 : err;
    if (tick && err_set) err_nxt[ptr] = 1'b1;
  end

  // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they are
  // reset with everything else; that discards any pending candidate on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      ptr       <= 2'd0;
      upd_valid <= 1'b0;
      upd_ch    <= 2'd0;
      err       <= '0;
      for (int i = 0; i < NCH; i++) begin
        stable_q[i] <= 2'b00;
        cand_q[i]   <= 2'b00;
        cnt_q[i]    <= 4'd0;
        init_q[i]   <= 1'b0;
        level_q[i]  <= '0;
      end
    end else begin
      upd_valid <= 1'b0;
      err       <= err_nxt;
      if (ena) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        stable_q[ptr] <= nxt_stable;
        cand_q[ptr]   <= nxt_cand;
        cnt_q[ptr]    <= nxt_cnt;
        init_q[ptr]   <= 1'b1;
        level_q[ptr]  <= nxt_level;
        upd_valid     <= upd;
        upd_ch        <= ptr;
        ptr           <= (ptr == 2'(NCH - 1)) ? 2'd0 : ptr + 2'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_level
    assign level[gi*WIDTH +: WIDTH] = level_q[gi];
  end

endmodule

// File: tb/tb_rgb_enc_scheduler.sv
// Directed bench for rgb_enc_scheduler with NCH=3, WIDTH=8, SCAN_DIV=4, DEBOUNCE=2.
module tb_rgb_enc_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [2:0]  enc_a;
  logic [2:0]  enc_b;
  logic        err_clr;
  logic [23:0] level;
  logic        upd_valid;
  logic [1:0]  upd_ch;
  logic [2:0]  err;

  int errors = 0;
  int checks = 0;
  int pulses [4] = '{0, 0, 0, 0};
  int back_to_back = 0;
  logic prev_upd = 1'b0;

  logic [1:0] fwd [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] rev [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  rgb_enc_scheduler #(
    .NCH(3), .WIDTH(8), .SCAN_DIV(4), .DEBOUNCE(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .err_clr   (err_clr),
    .level     (level),
    .upd_valid (upd_valid),
    .upd_ch    (upd_ch),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd_valid) begin
      pulses[upd_ch] = pulses[upd_ch] + 1;
      if (prev_upd) back_to_back = back_to_back + 1;
    end
    prev_upd = upd_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [1:0] v);
    enc_b[ch] = v[1];
    enc_a[ch] = v[0];
  endtask

  function automatic logic [7:0] lvl(input int ch);
    return level[ch*8 +: 8];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; err_clr = 1'b0; enc_a = '0; enc_b = '0;
    wait_clk(3);
    checks++;
    if (level !== 24'd0 || upd_valid !== 1'b0 || err !== 3'b000) begin
      errors++; $display("FAIL reset_hold: level=%h upd=%b err=%b expected 0", level, upd_valid, err);
    end
    rst_n = 1'b1;
    wait_clk(40);
    set_ch(0, 2'b01);
    wait_clk(40);
    checks++;
    if (lvl(0) !== 8'd1) begin
      errors++; $display("FAIL pre_reset_step: level0=%0d expected 1", lvl(0));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (level !== 24'd0) begin
      errors++; $display("FAIL async_reset: level=%h expected 0", level);
    end
    set_ch(0, 2'b00);
    wait_clk(2);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (level !== 24'd0 || err !== 3'b000 || upd_valid !== 1'b0) begin
      errors++; $display("FAIL post_release: level=%h err=%b upd=%b expected 0", level, err, upd_valid);
    end
    checks++;
    if (dut.ptr !== 2'd0) begin
      errors++; $display("FAIL post_release_ptr: ptr=%0d expected 0", dut.ptr);
    end
    wait_clk(40);
  endtask

  task automatic test_forward();
    int p0, p1, p2;
    p0 = pulses[0]; p1 = pulses[1]; p2 = pulses[2];
    for (int i = 0; i < 4; i++) begin
      set_ch(0, fwd[i]);
      wait_clk(40);
      checks++;
      if (lvl(0) !== 8'(i + 1)) begin
        errors++; $display("FAIL fwd_level step%0d: level0=%0d expected %0d", i, lvl(0), i + 1);
      end
    end
    checks++;
    if (pulses[0] - p0 !== 4) begin
      errors++; $display("FAIL fwd_pulses: got %0d expected 4", pulses[0] - p0);
    end
    checks++;
    if ((pulses[1] - p1) + (pulses[2] - p2) !== 0) begin
      errors++; $display("FAIL fwd_wrong_ch: got %0d pulses on ch1/ch2 expected 0", (pulses[1] - p1) + (pulses[2] - p2));
    end
  endtask

  task automatic test_saturation();
    int p1;
    p1 = pulses[1];
    for (int i = 0; i < 4; i++) begin
      set_ch(1, rev[i]);
      wait_clk(40);
    end
    checks++;
    if (lvl(1) !== 8'd0 || pulses[1] - p1 !== 0) begin
      errors++; $display("FAIL sat_low: level1=%0d pulses=%0d expected 0/0", lvl(1), pulses[1] - p1);
    end
    p1 = pulses[1];
    for (int i = 0; i < 260; i++) begin
      set_ch(1, fwd[i % 4]);
      wait_clk(40);
    end
    checks++;
    if (lvl(1) !== 8'd255) begin
      errors++; $display("FAIL sat_high_level: level1=%0d expected 255", lvl(1));
    end
    checks++;
    if (pulses[1] - p1 !== 255) begin
      errors++; $display("FAIL sat_high_pulses: got %0d expected 255", pulses[1] - p1);
    end
    checks++;
    if (lvl(0) !== 8'd4) begin
      errors++; $display("FAIL sat_isolation: level0=%0d expected 4", lvl(0));
    end
  endtask

  task automatic test_glitch();
    int p2;
    p2 = pulses[2];
    set_ch(2, 2'b01);
    wait_clk(12);
    set_ch(2, 2'b00);
    wait_clk(40);
    checks++;
    if (lvl(2) !== 8'd0 || pulses[2] - p2 !== 0 || err !== 3'b000) begin
      errors++; $display("FAIL glitch: level2=%0d pulses=%0d err=%b expected 0/0/000", lvl(2), pulses[2] - p2, err);
    end
  endtask

  task automatic test_illegal();
    int p2;
    p2 = pulses[2];
    set_ch(2, 2'b11);
    wait_clk(40);
    checks++;
    if (err !== 3'b100) begin
      errors++; $display("FAIL illegal_err: err=%b expected 100", err);
    end
    checks++;
    if (lvl(2) !== 8'd0 || pulses[2] - p2 !== 0) begin
      errors++; $display("FAIL illegal_level: level2=%0d pulses=%0d expected 0/0", lvl(2), pulses[2] - p2);
    end
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    checks++;
    if (err !== 3'b000) begin
      errors++; $display("FAIL err_clr: err=%b expected 000", err);
    end
    wait_clk(40);
    checks++;
    if (err !== 3'b000) begin
      errors++; $display("FAIL err_stays_clear: err=%b expected 000", err);
    end
  endtask

  task automatic test_init_hold();
    int ptot;
    enc_a = 3'b111; enc_b = 3'b111;
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    ptot = pulses[0] + pulses[1] + pulses[2];
    wait_clk(60);
    checks++;
    if (err !== 3'b000 || level !== 24'd0) begin
      errors++; $display("FAIL init_hold: err=%b level=%h expected 000/0", err, level);
    end
    checks++;
    if (pulses[0] + pulses[1] + pulses[2] - ptot !== 0) begin
      errors++; $display("FAIL init_pulses: got %0d expected 0", pulses[0] + pulses[1] + pulses[2] - ptot);
    end
  endtask

  task automatic test_ena_freeze();
    int p0;
    p0 = pulses[0];
    ena = 1'b0;
    set_ch(0, 2'b10);
    wait_clk(100);
    checks++;
    if (lvl(0) !== 8'd0 || pulses[0] - p0 !== 0) begin
      errors++; $display("FAIL ena_frozen: level0=%0d pulses=%0d expected 0/0", lvl(0), pulses[0] - p0);
    end
    ena = 1'b1;
    wait_clk(40);
    checks++;
    if (lvl(0) !== 8'd1) begin
      errors++; $display("FAIL ena_resume_level: level0=%0d expected 1", lvl(0));
    end
    checks++;
    if (pulses[0] - p0 !== 1) begin
      errors++; $display("FAIL ena_resume_pulses: got %0d expected 1", pulses[0] - p0);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_saturation();
    test_glitch();
    test_illegal();
    test_init_hold();
    test_ena_freeze();
    checks++;
    if (back_to_back !== 0) begin
      errors++; $display("FAIL upd_back_to_back: got %0d expected 0", back_to_back);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
